mips_main_control: RTL and testbench

Multicycle main control unit for the MIPS datapath. It decodes the instruction opcode into a Moore state machine that sequences fetch, decode, execute, memory and writeback. Each cycle it drives every datapath mux select and write enable, including the 2-bit ALUOp consumed by the ALU control stage directly downstream. It stalls on a memory ready handshake.

---
 rtl/mips_main_control.sv | 198 +++++++++++++++++++
 tb/tb_mips_main_control.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_main_control.sv
// Multicycle MIPS main control: Moore FSM sequencing fetch/decode/execute/memory/writeback.
// Optional addi support is compiled in when MIPS_MAIN_CTRL_ADDI_EN is defined.
module mips_main_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PCWriteCondN,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEMADR   = 4'd2;
    localparam logic [3:0] ST_MEMRD    = 4'd3;
    localparam logic [3:0] ST_MEMWB    = 4'd4;
    localparam logic [3:0] ST_MEMWR    = 4'd5;
    localparam logic [3:0] ST_RTYPE_EX = 4'd6;
    localparam logic [3:0] ST_RTYPE_WB = 4'd7;
    localparam logic [3:0] ST_BEQ      = 4'd8;
    localparam logic [3:0] ST_JUMP     = 4'd9;
`ifdef MIPS_MAIN_CTRL_ADDI_EN
    localparam logic [3:0] ST_ADDI_EX  = 4'd10;
    localparam logic [3:0] ST_ADDI_WB  = 4'd11;
`endif
    localparam logic [3:0] ST_BNE      = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
`ifdef MIPS_MAIN_CTRL_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'h08;
`endif
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [5:0] op_q;
    logic       op_legal;

    always_comb begin
        op_legal = 1'b0;
        unique case (opcode)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BNE, OP_J: op_legal = 1'b1;
`ifdef MIPS_MAIN_CTRL_ADDI_EN
            OP_ADDI: op_legal = 1'b1;
`endif
            default: op_legal = 1'b0;
        endcase
    end

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = ST_FETCH;
        unique case (state_q)
            ST_FETCH:  state_d = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                unique case (opcode)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYPE:     state_d = ST_RTYPE_EX;
                    OP_BEQ:       state_d = ST_BEQ;
                    OP_BNE:       state_d = ST_BNE;
                    OP_J:         state_d = ST_JUMP;
`ifdef MIPS_MAIN_CTRL_ADDI_EN
                    OP_ADDI:      state_d = ST_ADDI_EX;
`endif
                    default:      state_d = ST_FETCH;
                endcase
            end
            // Only lw/sw reach MEMADR, so the latched opcode is one of those two.
            ST_MEMADR:   state_d = (op_q == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:    state_d = mem_ready ? ST_MEMWB : ST_MEMRD;
            ST_MEMWR:    state_d = mem_ready ? ST_FETCH : ST_MEMWR;
            ST_RTYPE_EX: state_d = ST_RTYPE_WB;
`ifdef MIPS_MAIN_CTRL_ADDI_EN
            ST_ADDI_EX:  state_d = ST_ADDI_WB;
`endif
            default:     state_d = ST_FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            op_q    <= 6'h00;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                op_q <= opcode;
            end
        end
    end

    always_comb begin
        PCWrite      = 1'b0;
        PCWriteCond  = 1'b0;
        PCWriteCondN = 1'b0;
        IorD         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        MemtoReg     = 1'b0;
        RegDst       = 1'b0;
        RegWrite     = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        ALUOp        = 2'b00;
        PCSource     = 2'b00;
        illegal_op   = 1'b0;
        state        = 4'd0;
        // Reset masks every output so an aborted instruction cannot write anything.
        if (!rst) begin
            state = state_q;
            unique case (state_q)
                ST_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    PCWrite = mem_ready;
                    IRWrite = mem_ready;
                end
                ST_DECODE: begin
                    ALUSrcB    = 2'b11;
                    illegal_op = !op_legal;
                end
                ST_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                ST_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                ST_MEMWB: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                end
                ST_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                ST_RTYPE_EX: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                end
                ST_RTYPE_WB: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                ST_BEQ: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCSource    = 2'b01;
                    PCWriteCond = 1'b1;
                end
                ST_BNE: begin
                    ALUSrcA      = 1'b1;
                    ALUOp        = 2'b01;
                    PCSource     = 2'b01;
                    PCWriteCondN = 1'b1;
                end
                ST_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
`ifdef MIPS_MAIN_CTRL_ADDI_EN
                ST_ADDI_EX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                ST_ADDI_WB: begin
                    RegWrite = 1'b1;
                end
`endif
                default: begin
                    PCWrite = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_main_control.sv
// Self-checking bench for mips_main_control: instruction-plan reference model plus
// directed literal checks and randomized opcode/mem_ready/reset stimulus.
module tb_mips_main_control;

`ifdef MIPS_MAIN_CTRL_ADDI_EN
    localparam bit ADDI_EN = 1'b1;
`else
    localparam bit ADDI_EN = 1'b0;
`endif

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_write_cond_n;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
        logic [3:0] state;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, PCWriteCondN, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, illegal_op;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;

    mips_main_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCWriteCondN(PCWriteCondN),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    outs_t dut_o;
    assign dut_o = '{PCWrite, PCWriteCond, PCWriteCondN, IorD, MemRead, MemWrite, IRWrite,
                     MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
                     illegal_op, state};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: each opcode maps to the list of states it walks through after DECODE.
    function automatic int plan_step(input logic [5:0] op, input int idx);
        int p[$];
        case (op)
            6'h23:   p = '{2, 3, 4};
            6'h2B:   p = '{2, 5};
            6'h00:   p = '{6, 7};
            6'h04:   p = '{8};
            6'h05:   p = '{12};
            6'h02:   p = '{9};
            6'h08:   if (ADDI_EN) p = '{10, 11};
            default: p = {};
        endcase
        return (idx < p.size()) ? p[idx] : -1;
    endfunction

    function automatic outs_t model_out(input int st, input logic r, input logic mr,
                                        input logic [5:0] op);
        outs_t o = '0;
        if (r) return o;
        o.state = st[3:0];
        case (st)
            0:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.pc_write = mr; o.ir_write = mr; end
            1:  begin o.alu_src_b = 2'b11; o.illegal_op = (plan_step(op, 0) < 0); end
            2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            3:  begin o.mem_read = 1; o.iord = 1; end
            4:  begin o.mem_to_reg = 1; o.reg_write = 1; end
            5:  begin o.mem_write = 1; o.iord = 1; end
            6:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            7:  begin o.reg_dst = 1; o.reg_write = 1; end
            8:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_source = 2'b01; o.pc_write_cond = 1; end
            12: begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_source = 2'b01; o.pc_write_cond_n = 1; end
            9:  begin o.pc_write = 1; o.pc_source = 2'b10; end
            10: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            11: begin o.reg_write = 1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    int m_state = 0;
    int m_plan[$];

    always @(posedge clk) begin
        if (rst) begin
            m_plan.delete();
            m_state <= 0;
        end else if ((m_state == 0 || m_state == 3 || m_state == 5) && !mem_ready) begin
            m_state <= m_state;
        end else if (m_state == 0) begin
            m_state <= 1;
        end else if (m_state == 1) begin
            m_plan.delete();
            for (int i = 0; plan_step(opcode, i) >= 0; i++) m_plan.push_back(plan_step(opcode, i));
            m_state <= (m_plan.size() > 0) ? m_plan.pop_front() : 0;
        end else begin
            m_state <= (m_plan.size() > 0) ? m_plan.pop_front() : 0;
        end
    end

    always @(negedge clk) begin
        outs_t e;
        e = model_out(m_state, rst, mem_ready, opcode);
        check("PCWrite",      dut_o.pc_write,        e.pc_write);
        check("PCWriteCond",  dut_o.pc_write_cond,   e.pc_write_cond);
        check("PCWriteCondN", dut_o.pc_write_cond_n, e.pc_write_cond_n);
        check("IorD",         dut_o.iord,            e.iord);
        check("MemRead",      dut_o.mem_read,        e.mem_read);
        check("MemWrite",     dut_o.mem_write,       e.mem_write);
        check("IRWrite",      dut_o.ir_write,        e.ir_write);
        check("MemtoReg",     dut_o.mem_to_reg,      e.mem_to_reg);
        check("RegDst",       dut_o.reg_dst,         e.reg_dst);
        check("RegWrite",     dut_o.reg_write,       e.reg_write);
        check("ALUSrcA",      dut_o.alu_src_a,       e.alu_src_a);
        check("ALUSrcB",      dut_o.alu_src_b,       e.alu_src_b);
        check("ALUOp",        dut_o.alu_op,          e.alu_op);
        check("PCSource",     dut_o.pc_source,       e.pc_source);
        check("illegal_op",   dut_o.illegal_op,      e.illegal_op);
        check("state",        dut_o.state,           e.state);
    end

    // Apply inputs just after the rising edge, return at the falling edge for sampling.
    task automatic cyc(input logic r, input logic [5:0] op, input logic mr);
        @(posedge clk);
        #1;
        rst       = r;
        opcode    = op;
        mem_ready = mr;
        @(negedge clk);
    endtask

    initial begin
        int lw_seq[5];
        int rt_seq[4];
        int br_seq[3];
        lw_seq = '{0, 1, 2, 3, 4};
        rt_seq = '{0, 1, 6, 7};
        br_seq = '{0, 1, 8};
        rst = 1'b1;
        opcode = 6'h23;
        mem_ready = 1'b1;

        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 6'h23, 1'b1);
            check("reset_all_zero", dut_o, 0);
        end

        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 6'h23, 1'b1);
            check("lw_state", state, lw_seq[i]);
            check("lw_regwrite_mdr", {RegWrite, MemtoReg}, (i == 4) ? 2'b11 : 2'b00);
            if (i == 0) check("post_reset_fetch", {MemRead, ALUSrcB}, 3'b101);
        end

        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 6'h00, 1'b1);
            check("rtype_state", state, rt_seq[i]);
            if (i == 2) check("rtype_aluop", ALUOp, 2'b10);
            if (i == 3) check("rtype_wb", {RegWrite, RegDst}, 2'b11);
        end

        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 6'h04, 1'b1);
            check("beq_state", state, br_seq[i]);
            if (i == 2) check("beq_exec", {ALUOp, PCWriteCond}, 3'b011);
        end

        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 6'h2B, 1'b0);
            check("fetch_stall", {state, PCWrite, IRWrite}, 6'b000000);
        end
        cyc(1'b0, 6'h2B, 1'b1);
        check("fetch_ready", {PCWrite, IRWrite}, 2'b11);
        cyc(1'b0, 6'h2B, 1'b1);
        check("sw_decode", state, 1);
        cyc(1'b0, 6'h23, 1'b1);
        check("sw_memadr", state, 2);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 6'h23, (i == 3));
            check("sw_memwr", {state, MemWrite, IorD}, 6'b010111);
        end
        cyc(1'b0, 6'h3F, 1'b1);
        check("sw_done", state, 0);

        cyc(1'b0, 6'h3F, 1'b1);
        check("illegal_decode", {state, illegal_op}, 5'b00011);
        check("illegal_no_write", {RegWrite, MemWrite, PCWrite, PCWriteCond, PCWriteCondN, IRWrite}, 0);
        cyc(1'b0, 6'h3F, 1'b1);
        check("illegal_return", {state, illegal_op}, 5'b00000);
        cyc(1'b0, 6'h08, 1'b1);
        check("addi_decode", {state, illegal_op}, {4'd1, !ADDI_EN});
        cyc(1'b0, 6'h08, 1'b1);
        check("addi_next", state, ADDI_EN ? 10 : 0);

        cyc(1'b1, 6'h00, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 6'h00, 1'b1);
        check("reached_rtype_ex", state, 6);
        cyc(1'b1, 6'h00, 1'b1);
        check("rst_mid_regwrite", {state, RegWrite}, 5'b00000);
        cyc(1'b0, 6'h00, 1'b1);
        check("rst_mid_after", {state, RegWrite}, 5'b00000);

        for (int n = 0; n < 3000; n++) begin
            logic [5:0] op;
            int pick;
            logic [5:0] legal_ops[8];
            legal_ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h02, 6'h08, 6'h23};
            pick = $urandom_range(0, 9);
            op = (pick < 8) ? legal_ops[pick] : 6'($urandom_range(0, 63));
            cyc(($urandom_range(0, 99) == 0), op, ($urandom_range(0, 3) != 0));
        end

        @(posedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
